// File: rtl/pc_stack_if.sv
// Command and status bundle for pc_stack: the controller (master) issues commands,
// the PC block (slave) reports the PC and the return-stack status.
interface pc_stack_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned SPW   = $clog2(DEPTH + 1)
);
  logic             clk_en;
  logic             pc_inc;
  logic             load_pc;
  logic             branch;
  logic             call;
  logic             ret;
  logic             err_clr;
  logic [WIDTH-1:0] pc_input;
  logic [WIDTH-1:0] offset;
  logic             pc_oen;
  logic [WIDTH-1:0] pc_q;
  logic [SPW-1:0]   sp;
  logic             stack_full;
  logic             stack_empty;
  logic             err;

  modport master (
    output clk_en, pc_inc, load_pc, branch, call, ret, err_clr, pc_input, offset, pc_oen,
    input  pc_q, sp, stack_full, stack_empty, err
  );

  modport slave (
    input  clk_en, pc_inc, load_pc, branch, call, ret, err_clr, pc_input, offset, pc_oen,
    output pc_q, sp, stack_full, stack_empty, err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with increment/load/relative branch and a DEPTH-entry return-address
// LIFO; drives the shared bus through a tri-state buffer.
module pc_stack #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned     SPW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  pc_stack_if.slave        bus,
  output wire [WIDTH-1:0]  pc_out
);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [WIDTH-1:0] stack_d [DEPTH];

  logic             full, empty, err_event;
  logic [IdxW-1:0]  top_idx, push_idx;
  logic [WIDTH-1:0] pc_plus1;

  assign full     = (sp_q == SPW'(DEPTH));
  assign empty    = (sp_q == '0);
  assign top_idx  = IdxW'(sp_q - 1'b1);
  assign push_idx = IdxW'(sp_q);
  assign pc_plus1 = pc_q + 1'b1;

  always_comb begin
    pc_d      = pc_q;
    sp_d      = sp_q;
    stack_d   = stack_q;
    err_event = 1'b0;
    err_d     = err_q;
    if (bus.clk_en) begin
      // Fixed priority; losing commands are silently dropped.
      if (bus.ret) begin
        if (!empty) begin
          pc_d = stack_q[top_idx];
          sp_d = sp_q - 1'b1;
        end else begin
          err_event = 1'b1;
        end
      end else if (bus.call) begin
        if (!full) begin
          stack_d[push_idx] = pc_plus1;
          sp_d              = sp_q + 1'b1;
          pc_d              = bus.pc_input;
        end else begin
          err_event = 1'b1;
        end
      end else if (bus.load_pc) begin
        pc_d = bus.pc_input;
      end else if (bus.branch) begin
        pc_d = pc_q + bus.offset;
      end else if (bus.pc_inc) begin
        pc_d = pc_plus1;
      end
      // A new error beats a simultaneous clear.
      err_d = err_event | (err_q & ~bus.err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc_q  <= RESET_VAL;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Entries at or above sp are never read, so the array needs no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.pc_q        = pc_q;
  assign bus.sp          = sp_q;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.err         = err_q;
  assign pc_out          = bus.pc_oen ? pc_q : {WIDTH{1'bz}};
endmodule
